// File: rtl/control_unit_if.sv
// Datapath control bundle: the opcode going into the control unit and every
// strobe/select coming out of it, plus the state code exposed for debug.
interface control_unit_if;
    logic [2:0] opc;
    logic [1:0] ALUOP;
    logic       pcWriteUnCond;
    logic       pcWriteCond;
    logic       IorD;
    logic       memRead;
    logic       memWrite;
    logic       IRWrite;
    logic       MtoS;
    logic       push;
    logic       pop;
    logic       tos;
    logic       ldA;
    logic       ldB;
    logic       srcA;
    logic       srcB;
    logic       pcSrc;
    logic [3:0] state;

    modport master (
        input  opc,
        output ALUOP, pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite,
               IRWrite, MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc,
               state
    );

    modport slave (
        output opc,
        input  ALUOP, pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite,
               IRWrite, MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc,
               state
    );
endinterface

// File: rtl/control_unit.sv
// Moore control FSM for the stack-machine datapath: sequences fetch, decode,
// operand pops, ALU, pushes, memory access and jumps.
module control_unit (
    input  logic           clk,
    input  logic           rst,
    control_unit_if.master bus
);

    typedef enum logic [3:0] {
        RST0   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        POPA   = 4'd3,
        POPB   = 4'd4,
        ALU    = 4'd5,
        PUSHR  = 4'd6,
        MEMRD  = 4'd7,
        PUSHM  = 4'd8,
        MEMWR  = 4'd9,
        JMP    = 4'd10,
        TOS    = 4'd11,
        JZ     = 4'd12
    } state_t;

    typedef struct packed {
        logic [1:0] aluOp;
        logic       pcWriteUnCond;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       mToS;
        logic       push;
        logic       pop;
        logic       tos;
        logic       ldA;
        logic       ldB;
        logic       srcA;
        logic       srcB;
        logic       pcSrc;
    } ctrl_t;

    state_t     currentState;
    state_t     nextState;
    logic [2:0] opcodeReg;
    ctrl_t      outReg;

    // Strobes for a given state; op only matters for the ALU result states.
    function automatic ctrl_t decodeOutputs(input state_t s, input logic [2:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead       = 1'b1;
                c.irWrite       = 1'b1;
                c.srcA          = 1'b1;
                c.srcB          = 1'b1;
                c.pcWriteUnCond = 1'b1;
            end
            POPA: begin
                c.pop = 1'b1;
                c.ldA = 1'b1;
            end
            POPB: begin
                c.pop = 1'b1;
                c.ldB = 1'b1;
            end
            ALU:   c.aluOp = op[1:0];
            PUSHR: begin
                c.aluOp = op[1:0];
                c.push  = 1'b1;
            end
            MEMRD: begin
                c.iorD    = 1'b1;
                c.memRead = 1'b1;
            end
            PUSHM: begin
                c.mToS = 1'b1;
                c.push = 1'b1;
            end
            MEMWR: begin
                c.iorD     = 1'b1;
                c.memWrite = 1'b1;
            end
            JMP: begin
                c.pcSrc         = 1'b1;
                c.pcWriteUnCond = 1'b1;
            end
            TOS:   c.tos = 1'b1;
            JZ: begin
                c.pcSrc       = 1'b1;
                c.pcWriteCond = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Only DECODE looks at the live opcode; POPA branches on the latched copy.
    always_comb begin
        nextState = FETCH;
        case (currentState)
            RST0:   nextState = FETCH;
            FETCH:  nextState = DECODE;
            DECODE: begin
                case (bus.opc)
                    3'b100:  nextState = MEMRD;
                    3'b110:  nextState = JMP;
                    3'b111:  nextState = TOS;
                    default: nextState = POPA;
                endcase
            end
            POPA: begin
                case (opcodeReg)
                    3'b000, 3'b001, 3'b010: nextState = POPB;
                    3'b011:                 nextState = ALU;
                    3'b101:                 nextState = MEMWR;
                    default:                nextState = FETCH;
                endcase
            end
            POPB:    nextState = ALU;
            ALU:     nextState = PUSHR;
            MEMRD:   nextState = PUSHM;
            TOS:     nextState = JZ;
            default: nextState = FETCH;
        endcase
    end

    // Outputs are registered alongside the state they belong to, so they
    // remain a pure function of the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            currentState <= RST0;
            opcodeReg    <= 3'b000;
            outReg       <= '0;
        end else begin
            currentState <= nextState;
            outReg       <= decodeOutputs(nextState, opcodeReg);
            if (currentState == DECODE)
                opcodeReg <= bus.opc;
        end
    end

    assign bus.state         = currentState;
    assign bus.ALUOP         = outReg.aluOp;
    assign bus.pcWriteUnCond = outReg.pcWriteUnCond;
    assign bus.pcWriteCond   = outReg.pcWriteCond;
    assign bus.IorD          = outReg.iorD;
    assign bus.memRead       = outReg.memRead;
    assign bus.memWrite      = outReg.memWrite;
    assign bus.IRWrite       = outReg.irWrite;
    assign bus.MtoS          = outReg.mToS;
    assign bus.push          = outReg.push;
    assign bus.pop           = outReg.pop;
    assign bus.tos           = outReg.tos;
    assign bus.ldA           = outReg.ldA;
    assign bus.ldB           = outReg.ldB;
    assign bus.srcA          = outReg.srcA;
    assign bus.srcB          = outReg.srcB;
    assign bus.pcSrc         = outReg.pcSrc;

endmodule

// File: tb/tb_control_unit.sv
// Directed and randomised checks of the control FSM state trace and strobes.
module tb_control_unit;

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    logic sawLdB;
    logic sawMemWrite;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Packing order: ALUOP[16:15], pcWriteUnCond, pcWriteCond, IorD, memRead,
    // memWrite, IRWrite, MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc.
    function automatic logic [31:0] dutOuts();
        return {15'd0, bus.ALUOP, bus.pcWriteUnCond, bus.pcWriteCond, bus.IorD,
                bus.memRead, bus.memWrite, bus.IRWrite, bus.MtoS, bus.push,
                bus.pop, bus.tos, bus.ldA, bus.ldB, bus.srcA, bus.srcB, bus.pcSrc};
    endfunction

    function automatic logic [31:0] expOut(input logic [3:0] s, input logic [2:0] op);
        logic [1:0] aluOp;
        logic pcWUn, pcWC, iorD, mRd, mWr, irW, mToS, psh, pp, ts, lA, lB, sA, sB, pS;
        aluOp = 2'b00;
        {pcWUn, pcWC, iorD, mRd, mWr, irW, mToS, psh, pp, ts, lA, lB, sA, sB, pS} = '0;
        case (s)
            4'd1:  begin mRd = 1; irW = 1; sA = 1; sB = 1; pcWUn = 1; end
            4'd3:  begin pp = 1; lA = 1; end
            4'd4:  begin pp = 1; lB = 1; end
            4'd5:  aluOp = op[1:0];
            4'd6:  begin aluOp = op[1:0]; psh = 1; end
            4'd7:  begin iorD = 1; mRd = 1; end
            4'd8:  begin mToS = 1; psh = 1; end
            4'd9:  begin iorD = 1; mWr = 1; end
            4'd10: begin pS = 1; pcWUn = 1; end
            4'd11: ts = 1;
            4'd12: begin pS = 1; pcWC = 1; end
            default: ;
        endcase
        return {15'd0, aluOp, pcWUn, pcWC, iorD, mRd, mWr, irW, mToS, psh, pp,
                ts, lA, lB, sA, sB, pS};
    endfunction

    // Hand-written state traces after FETCH, first state in the low nibble.
    function automatic logic [23:0] seqFor(input logic [2:0] op, output int len);
        logic [23:0] seq;
        case (op)
            3'b000, 3'b001, 3'b010: begin seq = 24'h165432; len = 6; end
            3'b011:                 begin seq = 24'h016532; len = 5; end
            3'b100:                 begin seq = 24'h001872; len = 4; end
            3'b101:                 begin seq = 24'h001932; len = 4; end
            3'b110:                 begin seq = 24'h0001A2; len = 3; end
            default:                begin seq = 24'h001CB2; len = 4; end
        endcase
        return seq;
    endfunction

    task automatic stepAndCheck(input logic [3:0] expState, input logic [2:0] op);
        @(posedge clk);
        #1;
        sawLdB      = sawLdB | bus.ldB;
        sawMemWrite = sawMemWrite | bus.memWrite;
        checkOutput("state", {28'd0, bus.state}, {28'd0, expState});
        checkOutput("outputs", dutOuts(), expOut(expState, op));
        checkOutput("pushPopExcl", {31'd0, bus.push & bus.pop}, 32'd0);
        checkOutput("memRdWrExcl", {31'd0, bus.memRead & bus.memWrite}, 32'd0);
    endtask

    // Called while in FETCH; opc is scrambled once it has been latched.
    task automatic applyStimulus(input logic [2:0] op, input bit scramble);
        logic [23:0] seq;
        int          len;
        logic [3:0]  s;
        seq     = seqFor(op, len);
        bus.opc = op;
        for (int i = 0; i < len; i++) begin
            if (scramble && i >= 2)
                bus.opc = 3'($urandom_range(0, 7));
            s = seq[i*4 +: 4];
            stepAndCheck(s, op);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        sawLdB      = 1'b0;
        sawMemWrite = 1'b0;
        rst         = 1'b0;
        bus.opc     = 3'b100;

        #1;
        checkOutput("resetStateAsync", {28'd0, bus.state}, 32'd0);
        checkOutput("resetOutsAsync", dutOuts(), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("resetStateHeld", {28'd0, bus.state}, 32'd0);
        checkOutput("resetOutsHeld", dutOuts(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stepAndCheck(4'd1, 3'b000);

        applyStimulus(3'b100, 1'b0);
        applyStimulus(3'b000, 1'b0);
        applyStimulus(3'b001, 1'b0);
        applyStimulus(3'b010, 1'b0);
        sawLdB = 1'b0;
        applyStimulus(3'b011, 1'b0);
        checkOutput("notNoLdB", {31'd0, sawLdB}, 32'd0);
        applyStimulus(3'b111, 1'b0);
        applyStimulus(3'b110, 1'b0);
        applyStimulus(3'b101, 1'b0);

        // Abort a POP in POPA: MEMWR must never be reached.
        sawMemWrite = 1'b0;
        bus.opc     = 3'b101;
        stepAndCheck(4'd2, 3'b101);
        stepAndCheck(4'd3, 3'b101);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abortStateAsync", {28'd0, bus.state}, 32'd0);
        checkOutput("abortOutsAsync", dutOuts(), 32'd0);
        @(posedge clk);
        #1;
        sawMemWrite = sawMemWrite | bus.memWrite;
        checkOutput("abortStateHeld", {28'd0, bus.state}, 32'd0);
        checkOutput("abortOutsHeld", dutOuts(), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        stepAndCheck(4'd1, 3'b000);
        checkOutput("abortNoMemWrite", {31'd0, sawMemWrite}, 32'd0);

        // After reset the latched opcode is 000, so a NOT must still use its own.
        applyStimulus(3'b011, 1'b1);

        for (int n = 0; n < 1000; n++)
            applyStimulus(3'($urandom_range(0, 7)), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Port clk, input, 1: rising-edge clock for all state.
REQ-003 Port rst, input, 1: asynchronous active-low reset.
REQ-004 Port opc, input, 3: opcode from datapath instruction register; valid in DECODE.
REQ-005 Port ALUOP, output, 2: 00 add, 01 sub, 10 and, 11 not.
REQ-006 Ports pcWriteUnCond, pcWriteCond, IorD, memRead, memWrite, IRWrite, MtoS, push, pop, tos, ldA, ldB, srcA, srcB, pcSrc: outputs, 1 bit each, datapath strobes/selects.
REQ-007 Port state, output, 4: current FSM state code, for debug.

Function
REQ-008 Opcode map SHALL be: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH, 101 POP, 110 JMP, 111 JZ.
REQ-009 The FSM SHALL be Moore; all outputs SHALL decode from the state register only; any output not listed for a state SHALL be 0.
REQ-010 State codes SHALL be: RST0=0, FETCH=1, DECODE=2, POPA=3, POPB=4, ALU=5, PUSHR=6, MEMRD=7, PUSHM=8, MEMWR=9, JMP=10, TOS=11, JZ=12; codes 13-15 SHALL go to FETCH next cycle with all outputs 0.
REQ-011 RST0: all outputs 0; next FETCH.
REQ-012 FETCH: IorD=0, memRead=1, IRWrite=1, srcA=1, srcB=1, ALUOP=00, pcSrc=0, pcWriteUnCond=1; next DECODE.
REQ-013 DECODE: all outputs 0; opc SHALL be latched into an internal 3-bit opcode register; next POPA for ADD/SUB/AND/NOT/POP, MEMRD for PUSH, JMP for JMP, TOS for JZ.
REQ-014 POPA: pop=1, ldA=1; next POPB for ADD/SUB/AND, ALU for NOT, MEMWR for POP (from latched opcode).
REQ-015 POPB: pop=1, ldB=1; next ALU.
REQ-016 ALU: ALUOP = latched opcode[1:0], srcA=0, srcB=0; next PUSHR.
REQ-017 PUSHR: MtoS=0, push=1, ALUOP held as in ALU; next FETCH.
REQ-018 MEMRD: IorD=1, memRead=1; next PUSHM.
REQ-019 PUSHM: MtoS=1, push=1; next FETCH.
REQ-020 MEMWR: IorD=1, memWrite=1; next FETCH.
REQ-021 JMP: pcSrc=1, pcWriteUnCond=1; next FETCH.
REQ-022 TOS: tos=1 (zero flag loads); next JZ.
REQ-023 JZ: pcSrc=1, pcWriteCond=1; next FETCH; taken/not-taken SHALL not alter sequencing.
REQ-024 Instruction latency from FETCH entry to next FETCH SHALL be: ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4 cycles.
REQ-025 At most one of push/pop SHALL be 1 in any cycle; memRead and memWrite SHALL never both be 1.
REQ-026 opc changes outside DECODE SHALL not affect sequencing or outputs.

Reset
REQ-027 rst=0 SHALL force state to RST0 and the opcode register to 000 immediately, independent of clk; all outputs 0 while rst=0.
REQ-028 Reset asserted mid-instruction SHALL abort it with no further strobes; after rst release the first rising edge SHALL enter FETCH.

Verification
REQ-029 Reset release, opc=100 -> states 0,1,2,7,8,1; memRead=1 in 7; push=1, MtoS=1 in 8.
REQ-030 opc=000 -> states 1,2,3,4,5,6,1; ALUOP=00 in 5 and 6; ldA in 3, ldB in 4, push in 6.
REQ-031 opc=011 (NOT) -> states 1,2,3,5,6,1; ALUOP=11; ldB never asserted.
REQ-032 opc=111 -> states 1,2,11,12,1; tos=1 in 11; pcWriteCond=1, pcSrc=1 in 12; opc=110 -> 1,2,10,1 with pcWriteUnCond=1 in 10.
REQ-033 opc=101, rst pulsed low while in POPA -> state 0 asynchronously, memWrite never asserted, FETCH one edge after release.
REQ-034 opc toggled randomly outside DECODE across 1000 random instructions -> state trace matches REQ-013..023 per latched opcode; REQ-025 never violated.
